mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_hier_pkg.sv | 23 ++
 rtl/mem_responder_array.sv | 41 ++++
 rtl/mem_responder.sv | 147 ++++++++++++++
 tb/tb_mem_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_hier_pkg.sv
// rtl/mem_hier_pkg.sv - shared widths, FSM states and power-up image for the memory responder
package mem_hier_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Power-up image: words 0..3 hold a small descending pattern, the rest are zero.
   function automatic logic [DATA_W-1:0] power_up_word(input int unsigned a);
      case (a)
         0:       return 8'h05;
         1:       return 8'h03;
         2:       return 8'h01;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/mem_responder_array.sv
// rtl/mem_responder_array.sv - word storage with synchronous write and registered read
module mem_responder_array
   import mem_hier_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              en,
   input  logic              write,
   input  logic              hit,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] words [DEPTH];

   // Storage carries its power-up image and is deliberately outside the reset domain.
   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      localparam logic [DATA_W-1:0] INIT = power_up_word(i);
      logic [DATA_W-1:0] word_q = INIT;

      always_ff @(posedge clock) begin
         if (en && write && hit && addr == ADDR_W'(i))
            word_q <= wdata;
      end

      assign words[i] = word_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         rdata <= '0;
      else if (en)
         rdata <= (hit && !write) ? words[addr[IW-1:0]] : '0;
   end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - latency-modelling memory responder; MEM_RESPONDER_COUNT_EN enables access counters
module mem_responder
   import mem_hier_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_hit,
   output logic [15:0]       read_count,
   output logic [15:0]       write_count
);

   localparam logic [3:0]      WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
   localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);

   state_t            state, next_state;
   logic [3:0]        wait_cnt;
   logic              accept, commit, handshake;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              cm_write, cm_hit;
   logic [ADDR_W-1:0] cm_addr;
   logic [DATA_W-1:0] cm_wdata;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      accept     = 1'b0;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept = 1'b1;
               if (LATENCY == 0) begin
                  next_state = RESP;
                  commit     = 1'b1;
               end else begin
                  next_state = WAIT;
               end
            end
         end
         WAIT: begin
            if (wait_cnt == 4'd0) begin
               next_state = RESP;
               commit     = 1'b1;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign handshake = resp_valid && resp_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         if (accept) begin
            wait_cnt <= WAIT_LOAD;
            write_q  <= req_write;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
         end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
      end
   end

   // With zero latency the commit happens on the accept edge, so the live inputs are used.
   assign cm_write = (state == IDLE) ? req_write : write_q;
   assign cm_addr  = (state == IDLE) ? req_addr  : addr_q;
   assign cm_wdata = (state == IDLE) ? req_wdata : wdata_q;
   assign cm_hit   = {1'b0, cm_addr} < DEPTH_L;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         resp_hit <= 1'b0;
      else if (commit)
         resp_hit <= cm_hit;
   end

   mem_responder_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clock (clock),
      .reset (reset),
      .en    (commit && !reset),
      .write (cm_write),
      .hit   (cm_hit),
      .addr  (cm_addr),
      .wdata (cm_wdata),
      .rdata (resp_rdata)
   );

`ifdef MEM_RESPONDER_COUNT_EN
   logic [15:0] read_cnt, write_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         read_cnt  <= '0;
         write_cnt <= '0;
      end else if (handshake) begin
         if (write_q) begin
            if (write_cnt != 16'hFFFF)
               write_cnt <= write_cnt + 16'd1;
         end else if (read_cnt != 16'hFFFF) begin
            read_cnt <= read_cnt + 16'd1;
         end
      end
   end

   assign read_count  = read_cnt;
   assign write_count = write_cnt;
`else
   assign read_count  = '0;
   assign write_count = '0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder (LATENCY=2/DEPTH=4 and LATENCY=0 instances)
module tb_mem_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic        m_req_valid = 1'b0, m_req_ready, m_req_write = 1'b0;
   logic [7:0]  m_req_addr = '0, m_req_wdata = '0;
   logic        m_resp_valid, m_resp_ready = 1'b0, m_resp_hit;
   logic [7:0]  m_resp_rdata;
   logic [15:0] m_read_count, m_write_count;

   logic        f_req_valid = 1'b0, f_req_ready, f_req_write = 1'b0;
   logic [7:0]  f_req_addr = '0, f_req_wdata = '0;
   logic        f_resp_valid, f_resp_ready = 1'b0, f_resp_hit;
   logic [7:0]  f_resp_rdata;
   logic [15:0] f_read_count, f_write_count;

   int compared   = 0;
   int mismatched = 0;
   int cycles     = 0;

`ifdef MEM_RESPONDER_COUNT_EN
   localparam int EXP_RD = 3;
   localparam int EXP_WR = 2;
`else
   localparam int EXP_RD = 0;
   localparam int EXP_WR = 0;
`endif

   logic       f_w_tab    [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [7:0] f_addr_tab [5] = '{8'h10, 8'h10, 8'h00, 8'h00, 8'h00};
   logic [7:0] f_data_tab [5] = '{8'h11, 8'h00, 8'h00, 8'h22, 8'h00};
   logic [7:0] f_exp_tab  [5] = '{8'h00, 8'h11, 8'h05, 8'h00, 8'h22};

   always #5 clock = ~clock;
   always @(posedge clock) cycles++;

   mem_responder #(.DEPTH(4), .LATENCY(2)) u_dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (m_req_valid),
      .req_ready   (m_req_ready),
      .req_write   (m_req_write),
      .req_addr    (m_req_addr),
      .req_wdata   (m_req_wdata),
      .resp_valid  (m_resp_valid),
      .resp_ready  (m_resp_ready),
      .resp_rdata  (m_resp_rdata),
      .resp_hit    (m_resp_hit),
      .read_count  (m_read_count),
      .write_count (m_write_count)
   );

   mem_responder #(.DEPTH(256), .LATENCY(0)) u_fast (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (f_req_valid),
      .req_ready   (f_req_ready),
      .req_write   (f_req_write),
      .req_addr    (f_req_addr),
      .req_wdata   (f_req_wdata),
      .resp_valid  (f_resp_valid),
      .resp_ready  (f_resp_ready),
      .resp_rdata  (f_resp_rdata),
      .resp_hit    (f_resp_hit),
      .read_count  (f_read_count),
      .write_count (f_write_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one request from a negedge, then scramble the inputs and count edges to resp_valid.
   task automatic m_issue(input logic w, input logic [7:0] a, input logic [7:0] d, output int n);
      check("m_ready_before_req", m_req_ready, 1);
      m_req_valid = 1'b1;
      m_req_write = w;
      m_req_addr  = a;
      m_req_wdata = d;
      @(negedge clock);
      m_req_valid = 1'b0;
      m_req_write = ~w;
      m_req_addr  = ~a;
      m_req_wdata = ~d;
      n = 1;
      while (m_resp_valid !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
   endtask

   task automatic m_expect(input string tag, input int n, input logic [7:0] rd, input logic hit);
      check({tag, "_latency"}, n, 3);
      check({tag, "_valid"}, m_resp_valid, 1);
      check({tag, "_rdata"}, m_resp_rdata, rd);
      check({tag, "_hit"}, m_resp_hit, hit);
   endtask

   task automatic m_complete(input string tag);
      m_resp_ready = 1'b1;
      @(negedge clock);
      m_resp_ready = 1'b0;
      check({tag, "_done_valid"}, m_resp_valid, 0);
      check({tag, "_done_ready"}, m_req_ready, 1);
   endtask

   initial begin
      int n;
      int start;

      // Reset state
      @(negedge clock);
      @(negedge clock);
      check("rst_req_ready", m_req_ready, 1);
      check("rst_resp_valid", m_resp_valid, 0);
      check("rst_rdata", m_resp_rdata, 8'h00);
      check("rst_hit", m_resp_hit, 0);
      check("rst_read_count", m_read_count, 0);
      check("rst_write_count", m_write_count, 0);
      reset = 1'b0;
      @(negedge clock);

      // Read of power-up word 1
      m_issue(1'b0, 8'h01, 8'h00, n);
      m_expect("rd01", n, 8'h03, 1'b1);
      m_complete("rd01");

      // Write then read back
      m_issue(1'b1, 8'h02, 8'hA5, n);
      m_expect("wr02", n, 8'h00, 1'b1);
      m_complete("wr02");
      m_issue(1'b0, 8'h02, 8'h00, n);
      m_expect("rd02", n, 8'hA5, 1'b1);
      m_complete("rd02");

      // Miss with DEPTH=4: address 9 must not alias onto word 1
      m_issue(1'b1, 8'h09, 8'h77, n);
      m_expect("wr09", n, 8'h00, 1'b0);
      m_complete("wr09");
      m_issue(1'b0, 8'h09, 8'h00, n);
      m_expect("rd09", n, 8'h00, 1'b0);
      m_complete("rd09");
      m_issue(1'b0, 8'h01, 8'h00, n);
      m_expect("rd01_after_miss", n, 8'h03, 1'b1);
      m_complete("rd01_after_miss");

      // Backpressure with a competing request that must be dropped
      m_issue(1'b0, 8'h00, 8'h00, n);
      m_expect("bp_rd00", n, 8'h05, 1'b1);
      m_req_valid = 1'b1;
      m_req_write = 1'b1;
      m_req_addr  = 8'h03;
      m_req_wdata = 8'hEE;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("bp_valid", m_resp_valid, 1);
         check("bp_rdata", m_resp_rdata, 8'h05);
         check("bp_hit", m_resp_hit, 1);
         check("bp_req_ready", m_req_ready, 0);
      end
      m_req_valid = 1'b0;
      m_complete("bp");
      @(negedge clock);
      check("bp_not_queued_valid", m_resp_valid, 0);
      check("bp_not_queued_ready", m_req_ready, 1);

      // Reset during WAIT of a write to word 0
      check("rw_ready_before_req", m_req_ready, 1);
      m_req_valid = 1'b1;
      m_req_write = 1'b1;
      m_req_addr  = 8'h00;
      m_req_wdata = 8'h5A;
      @(negedge clock);
      m_req_valid = 1'b0;
      check("rw_in_wait_valid", m_resp_valid, 0);
      check("rw_in_wait_ready", m_req_ready, 0);
      reset = 1'b1;
      #1;
      check("rw_rst_req_ready", m_req_ready, 1);
      check("rw_rst_resp_valid", m_resp_valid, 0);
      check("rw_rst_rdata", m_resp_rdata, 8'h00);
      check("rw_rst_hit", m_resp_hit, 0);
      check("rw_rst_read_count", m_read_count, 0);
      check("rw_rst_write_count", m_write_count, 0);
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      check("rw_rst_hold_valid", m_resp_valid, 0);
      reset = 1'b0;
      @(negedge clock);
      m_issue(1'b0, 8'h00, 8'h00, n);
      m_expect("rw_rd00", n, 8'h05, 1'b1);
      m_complete("rw_rd00");
      m_issue(1'b0, 8'h03, 8'h00, n);
      m_expect("bp_rd03", n, 8'h00, 1'b1);
      m_complete("bp_rd03");

      // LATENCY=0 instance: 2 writes and 3 reads back to back
      f_resp_ready = 1'b1;
      f_req_valid  = 1'b1;
      f_req_write  = f_w_tab[0];
      f_req_addr   = f_addr_tab[0];
      f_req_wdata  = f_data_tab[0];
      start = cycles;
      for (int i = 0; i < 5; i++) begin
         check("f_req_ready_idle", f_req_ready, 1);
         @(negedge clock);
         check("f_resp_valid", f_resp_valid, 1);
         check("f_rdata", f_resp_rdata, f_exp_tab[i]);
         check("f_hit", f_resp_hit, 1);
         check("f_req_ready_busy", f_req_ready, 0);
         if (i < 4) begin
            f_req_write = f_w_tab[i+1];
            f_req_addr  = f_addr_tab[i+1];
            f_req_wdata = f_data_tab[i+1];
         end else begin
            f_req_valid = 1'b0;
         end
         @(negedge clock);
         check("f_resp_done", f_resp_valid, 0);
      end
      check("f_cycles", cycles - start, 10);
      check("f_read_count", f_read_count, EXP_RD);
      check("f_write_count", f_write_count, EXP_WR);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
